// File: rtl/registro_arranque_multicanal.sv
// Bank of PicoBlaze-written start flags with per-channel start strobe and status readback.
// Optional timeout abort with sticky error enabled by defining REGISTRO_ARRANQUE_TIMEOUT_EN.
module registro_arranque_multicanal #(
   parameter int          NUM_CH         = 4,
   parameter logic [7:0]  BASE_ADDR      = 8'h10,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EN,
   input  logic              W_Strobe,
   input  logic [7:0]        port_id,
   input  logic [7:0]        port_out,
   input  logic [NUM_CH-1:0] listo,
   output logic [NUM_CH-1:0] dato_salida,
   output logic [NUM_CH-1:0] start_pulse,
   output logic [7:0]        dato_leido
);

   localparam logic [7:0] CMD_CLEAR = 8'h00;
   localparam logic [7:0] CMD_START = 8'h01;
   localparam logic [7:0] CMD_ACK   = 8'h02;

   if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 2 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
      $error("registro_arranque_multicanal: invalid parameter set");
   end

   logic [NUM_CH-1:0] r_flag;
   logic [NUM_CH-1:0] r_pulse;
   logic [NUM_CH-1:0] w_hit;
   logic [NUM_CH-1:0] w_err;
   logic [NUM_CH-1:0] w_timeout;
   logic [7:0]        w_read;
   logic [7:0]        r_read;

   always_comb begin
      w_hit = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_hit[k] = EN && W_Strobe && (port_id == 8'(BASE_ADDR + k));
      end
   end

`ifdef REGISTRO_ARRANQUE_TIMEOUT_EN
   logic [NUM_CH-1:0] r_err;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];

   always_comb begin
      w_timeout = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_timeout[k] = r_flag[k] && (r_cnt[k] == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   // Counter restarts on an accepted START and saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (!listo[k] && !r_flag[k] && w_hit[k] && port_out == CMD_START)
               r_cnt[k] <= '0;
            else if (r_flag[k] && r_cnt[k] != {CNT_W{1'b1}})
               r_cnt[k] <= r_cnt[k] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (listo[k])
               r_err[k] <= r_err[k];
            else if (w_timeout[k])
               r_err[k] <= 1'b1;
            else if (w_hit[k] && port_out == CMD_ACK)
               r_err[k] <= 1'b0;
         end
      end
   end

   assign w_err = r_err;
`else
   assign w_timeout = '0;
   assign w_err     = '0;
`endif

   // Per channel: listo beats timeout, timeout beats any write command.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_flag  <= '0;
         r_pulse <= '0;
      end else begin
         r_pulse <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (listo[k]) begin
               r_flag[k] <= 1'b0;
            end else if (w_timeout[k]) begin
               r_flag[k] <= 1'b0;
            end else if (w_hit[k]) begin
               if (port_out == CMD_START && !r_flag[k]) begin
                  r_flag[k]  <= 1'b1;
                  r_pulse[k] <= 1'b1;
               end else if (port_out == CMD_CLEAR) begin
                  r_flag[k] <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      w_read = 8'h00;
      for (int k = 0; k < NUM_CH; k++) begin
         if (port_id == 8'(BASE_ADDR + k))
            w_read = {5'b0, w_err[k], r_flag[k] && !listo[k], r_flag[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_read <= 8'h00;
      else      r_read <= w_read;
   end

   assign dato_salida = r_flag;
   assign start_pulse = r_pulse;
   assign dato_leido  = r_read;

endmodule

// File: tb/tb_registro_arranque_multicanal.sv
// Directed, table-driven bench for registro_arranque_multicanal (NUM_CH=4, BASE_ADDR=8'h10, TIMEOUT_CYCLES=16).
module tb_registro_arranque_multicanal;

   logic       clk = 1'b0;
   logic       rst;
   logic       EN;
   logic       W_Strobe;
   logic [7:0] port_id;
   logic [7:0] port_out;
   logic [3:0] listo;
   logic [3:0] dato_salida;
   logic [3:0] start_pulse;
   logic [7:0] dato_leido;

   int checkCount = 0;
   int errorCount = 0;

   registro_arranque_multicanal #(
      .NUM_CH(4), .BASE_ADDR(8'h10), .TIMEOUT_CYCLES(16), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .EN(EN), .W_Strobe(W_Strobe), .port_id(port_id),
      .port_out(port_out), .listo(listo), .dato_salida(dato_salida),
      .start_pulse(start_pulse), .dato_leido(dato_leido)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rstN;
      logic       en;
      logic       ws;
      logic [7:0] pid;
      logic [7:0] pout;
      logic [3:0] lst;
      logic [3:0] expOut;
      logic [3:0] expPulse;
      logic [7:0] expRd;
   } vec_t;

   vec_t vecs [27];

   // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic applyStimulus(input logic rstN, input logic en, input logic ws,
                                input logic [7:0] pid, input logic [7:0] pout, input logic [3:0] lst);
      @(negedge clk);
      rst = rstN; EN = en; W_Strobe = ws; port_id = pid; port_out = pout; listo = lst;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] eOut, input logic [3:0] ePulse, input logic [7:0] eRd);
      checkOutput({tag, " dato_salida"}, {4'h0, dato_salida}, {4'h0, eOut});
      checkOutput({tag, " start_pulse"}, {4'h0, start_pulse}, {4'h0, ePulse});
      checkOutput({tag, " dato_leido"}, dato_leido, eRd);
   endtask

   initial begin
      rst = 1'b0; EN = 1'b0; W_Strobe = 1'b0; port_id = 8'h00; port_out = 8'h00; listo = 4'h0;

      //         rstN en ws pid    pout   lst      out      pulse    rd
      vecs[0]  = '{0, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[1]  = '{1, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[2]  = '{1, 1, 1, 8'h12, 8'h01, 4'b0000, 4'b0100, 4'b0100, 8'h00};
      vecs[3]  = '{1, 0, 0, 8'h12, 8'h00, 4'b0000, 4'b0100, 4'b0000, 8'h03};
      vecs[4]  = '{1, 0, 0, 8'h12, 8'h00, 4'b0100, 4'b0000, 4'b0000, 8'h01};
      vecs[5]  = '{1, 0, 0, 8'h12, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[6]  = '{1, 1, 1, 8'h11, 8'h01, 4'b0010, 4'b0000, 4'b0000, 8'h00};
      vecs[7]  = '{1, 0, 0, 8'h11, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[8]  = '{1, 1, 1, 8'h10, 8'h01, 4'b0000, 4'b0001, 4'b0001, 8'h00};
      vecs[9]  = '{1, 0, 0, 8'h10, 8'h00, 4'b0000, 4'b0001, 4'b0000, 8'h03};
      vecs[10] = '{1, 0, 0, 8'h10, 8'h00, 4'b0000, 4'b0001, 4'b0000, 8'h03};
      vecs[11] = '{1, 1, 1, 8'h10, 8'h01, 4'b0000, 4'b0001, 4'b0000, 8'h03};
      vecs[12] = '{1, 1, 1, 8'h14, 8'h01, 4'b0000, 4'b0001, 4'b0000, 8'h00};
      vecs[13] = '{1, 1, 1, 8'h0F, 8'h01, 4'b0000, 4'b0001, 4'b0000, 8'h00};
      vecs[14] = '{1, 0, 1, 8'h11, 8'h01, 4'b0000, 4'b0001, 4'b0000, 8'h00};
      vecs[15] = '{1, 1, 0, 8'h11, 8'h01, 4'b0000, 4'b0001, 4'b0000, 8'h00};
      vecs[16] = '{1, 1, 1, 8'h10, 8'h07, 4'b0000, 4'b0001, 4'b0000, 8'h03};
      vecs[17] = '{1, 1, 1, 8'h10, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h03};
      vecs[18] = '{1, 0, 0, 8'h10, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[19] = '{1, 1, 1, 8'h11, 8'h01, 4'b0000, 4'b0010, 4'b0010, 8'h00};
      vecs[20] = '{1, 1, 1, 8'h12, 8'h01, 4'b0000, 4'b0110, 4'b0100, 8'h00};
      vecs[21] = '{1, 1, 1, 8'h13, 8'h01, 4'b0000, 4'b1110, 4'b1000, 8'h00};
      vecs[22] = '{1, 1, 1, 8'h10, 8'h01, 4'b0000, 4'b1111, 4'b0001, 8'h00};
      vecs[23] = '{1, 0, 0, 8'h13, 8'h00, 4'b0000, 4'b1111, 4'b0000, 8'h03};
      vecs[24] = '{0, 1, 1, 8'h13, 8'h01, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[25] = '{1, 0, 0, 8'h13, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00};
      vecs[26] = '{1, 0, 0, 8'h13, 8'h00, 4'b1111, 4'b0000, 4'b0000, 8'h00};

      for (int i = 0; i < 27; i++) begin
         applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].ws, vecs[i].pid, vecs[i].pout, vecs[i].lst);
         checkAll($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expPulse, vecs[i].expRd);
      end

`ifdef REGISTRO_ARRANQUE_TIMEOUT_EN
      // Channel 3 times out 16 cycles after being set.
      applyStimulus(1, 1, 1, 8'h13, 8'h01, 4'b0000);
      checkAll("to_start", 4'b1000, 4'b1000, 8'h00);
      for (int n = 1; n < 16; n++) begin
         applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
         checkOutput($sformatf("to_hold%0d", n), {7'h0, dato_salida[3]}, 8'h01);
      end
      applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
      checkAll("to_abort", 4'b0000, 4'b0000, 8'h03);
      applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
      checkAll("to_errread", 4'b0000, 4'b0000, 8'h04);
      applyStimulus(1, 1, 1, 8'h13, 8'h01, 4'b0000);
      checkAll("to_restart_err", 4'b1000, 4'b1000, 8'h04);
      applyStimulus(1, 1, 1, 8'h13, 8'h02, 4'b0000);
      checkAll("to_ack", 4'b1000, 4'b0000, 8'h07);
      applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b1000);
      checkAll("to_listo3", 4'b0000, 4'b0000, 8'h01);
      applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
      checkAll("to_acked", 4'b0000, 4'b0000, 8'h00);

      // listo arriving on the timeout cycle wins: no error.
      applyStimulus(1, 1, 1, 8'h12, 8'h01, 4'b0000);
      checkAll("tie_start", 4'b0100, 4'b0100, 8'h00);
      for (int n = 1; n < 16; n++) applyStimulus(1, 0, 0, 8'h12, 8'h00, 4'b0000);
      checkOutput("tie_hold", {4'h0, dato_salida}, 8'h04);
      applyStimulus(1, 0, 0, 8'h12, 8'h00, 4'b0100);
      checkAll("tie_listo", 4'b0000, 4'b0000, 8'h01);
      applyStimulus(1, 0, 0, 8'h12, 8'h00, 4'b0000);
      checkAll("tie_noerr", 4'b0000, 4'b0000, 8'h00);
`else
      // Without the timeout feature the flag is held and ACK_ERR does nothing.
      applyStimulus(1, 1, 1, 8'h13, 8'h01, 4'b0000);
      checkAll("hold_start", 4'b1000, 4'b1000, 8'h00);
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
         checkOutput($sformatf("hold%0d", n), {7'h0, dato_salida[3]}, 8'h01);
      end
      checkOutput("hold_read", dato_leido, 8'h03);
      applyStimulus(1, 1, 1, 8'h13, 8'h02, 4'b0000);
      checkAll("hold_ack", 4'b1000, 4'b0000, 8'h03);
      applyStimulus(1, 1, 1, 8'h13, 8'h00, 4'b0000);
      checkAll("hold_clear", 4'b0000, 4'b0000, 8'h03);
      applyStimulus(1, 0, 0, 8'h13, 8'h00, 4'b0000);
      checkAll("hold_idle", 4'b0000, 4'b0000, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
